load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sequences CPU data accesses onto the data port (port B) of the OTTER SRAM.
//  Accepts one load/store request at a time from the multicycle control path and checks alignment and range.
//  Drives the SRAM port-B controls for exactly one access cycle and waits out the synchronous read latency.
//  Returns a one-cycle registered response: load data or store completion, plus a fault flag.
// PARAMETERS
//  ADDR_WIDTH   25  byte-address width of SRAM; addr >= 2**ADDR_WIDTH faults (must match SRAM instance)
//  RD_LATENCY   1   clock edges from mem_read assertion to valid mem_rdata (>=1)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   CPU presents a request
//  req_ready    out  1   LSU can accept; handshake = req_valid & req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_sign     in   1   0 = signed, 1 = unsigned (load extension)
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, unshifted (rs2)
//  rsp_valid    out  1   one-cycle pulse: request finished
//  rsp_rdata    out  32  extended load data; 0 for stores/faults
//  rsp_err      out  1   valid with rsp_valid: misaligned/illegal size/out of range
//  mem_read     out  1   to SRAM read_B
//  mem_write    out  1   to SRAM write_B
//  mem_sign     out  1   to SRAM sign_B
//  mem_size     out  2   to SRAM size_B
//  mem_addr     out  32  to SRAM addr_B
//  mem_wdata    out  32  to SRAM wr_data_B (SRAM does lane shifting)
//  mem_rdata    in   32  from SRAM rd_data_B (sliced/extended by SRAM)
// BEHAVIOUR
//  Reset: state IDLE. Latency counter = 0. All mem_* and rsp_* outputs = 0. req_ready = 1.
//  FSM states: IDLE, ACCESS, WAIT, RESP.
//  IDLE
//   - req_ready = 1.
//   - On handshake, register sign/size/addr/wdata/we.
//   - Fault check on the request values: size==11, or half with addr[0]=1, or word with addr[1:0]!=0, or addr>=2**ADDR_WIDTH.
//   - Fault -> RESP with err latched. No mem_read/mem_write ever asserted.
//   - Otherwise -> ACCESS.
//  ACCESS (1 cycle)
//   - mem_read = ~we, mem_write = we.
//   - Store -> RESP; SRAM commits at this edge.
//   - Load -> WAIT with counter = RD_LATENCY-1.
//  WAIT
//   - mem_read = 0.
//   - Counter == 0: register mem_rdata into rsp_rdata and -> RESP. Otherwise decrement.
//  RESP (1 cycle)
//   - rsp_valid = 1 with registered rsp_rdata/rsp_err.
//   - Then -> IDLE. rsp_rdata/rsp_err clear on IDLE entry.
//  req_ready = 0 outside IDLE. req_valid there is ignored; no queueing.
//  mem_addr/mem_size/mem_sign hold the latched request from ACCESS through RESP.
//   - Required: SRAM slices its read register combinationally with these inputs.
//   - They are 0 in IDLE.
//  mem_read and mem_write never assert together. Each is high for at most 1 cycle per request.
//  Latency, handshake edge -> rsp_valid cycle:
//   - load = 2+RD_LATENCY cycles
//   - store = 2 cycles
//   - fault = 1 cycle
//  Back-to-back: a new request is accepted in the IDLE cycle right after RESP; no extra bubble.
//  Reset mid-operation: asynchronous return to IDLE.
//   - mem_write drops immediately, so no byte is written if reset precedes the ACCESS edge.
//   - A pending response is discarded (no rsp_valid).
//  req_wdata passes unmodified; lane shifting and byte enables belong to the SRAM.
// STRUCTURE
//  lsu_pkg:
//   - size_e {BYTE=2'b00, HALF=2'b01, WORD=2'b10}
//   - sign_e {SIGNED=1'b0, UNSIGNED=1'b1}
//   - lsu_state_e {IDLE, ACCESS, WAIT, RESP}
//  Size/sign enums are shared with the SRAM.
//  Sub-module lsu_fault_check: purely combinational (addr, size) -> fault, parameterised by ADDR_WIDTH.
//  FSM, request register and latency counter live in the top.
// TESTING
//  1. Store word 0xDEADBEEF @0x100, then load word @0x100 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
//     Load rsp_valid arrives 3 cycles after handshake (RD_LATENCY=1).
//  2. Store byte 0x80 @0x103, then load signed byte @0x103 -> 0xFFFFFF80; unsigned byte -> 0x00000080.
//  3. Load half @0x101, word @0x102, size=11 -> rsp_err=1 one cycle after handshake.
//     Check: mem_read/mem_write stay 0 throughout.
//  4. Load @0x0200_0000 (ADDR_WIDTH=25) -> rsp_err=1, no memory access.
//  5. Hold req_valid=1 continuously with alternating store/load -> one accept per transaction.
//     Check: req_ready low outside IDLE, no lost or duplicated requests.
//  6. Assert rst_n=0 during ACCESS of a store to 0x200 -> word at 0x200 unchanged, no rsp_valid.
//     Outputs are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit and the OTTER SRAM data port.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_e;

  typedef enum logic {
    SIGNED   = 1'b0,
    UNSIGNED = 1'b1
  } sign_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_fault_check.sv
// Combinational request screen: illegal size, misalignment or address beyond the SRAM.
module lsu_fault_check
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 25
) (
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  output logic        fault_o
);

  logic out_of_range;
  logic misaligned;

  generate
    if (ADDR_WIDTH < 32) begin : g_range
      assign out_of_range = |addr_i[31:ADDR_WIDTH];
    end else begin : g_full
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    misaligned = 1'b0;
    case (size_i)
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = addr_i[0];
      WORD:    misaligned = |addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign fault_o = misaligned | out_of_range;

endmodule

// File: rtl/load_store_unit.sv
// Sequences one CPU load/store at a time onto SRAM port B.
// state  | meaning
// IDLE   | ready for a request, memory port quiet
// ACCESS | one-cycle read/write strobe to the SRAM
// WAIT   | counting out the SRAM read latency
// RESP   | one-cycle response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 25,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_sign,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_sign,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              sign_q, sign_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              fault;
  logic              busy;

  lsu_fault_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_fault_check (
    .addr_i  (req_addr),
    .size_i  (req_size),
    .fault_o (fault)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sign_d  = sign_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          sign_d  = req_sign;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = fault;
          state_d = fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sign_q  <= sign_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The SRAM slices its read register with these, so they must hold until RESP ends.
  assign busy      = (state_q != IDLE);
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_size  = busy ? size_q  : 2'b00;
  assign mem_sign  = busy ? sign_q  : 1'b0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign mem_read  = (state_q == ACCESS) & ~we_q;
  assign mem_write = (state_q == ACCESS) & we_q;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
